// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchronized, threshold-debounced inputs with edge pulses, sticky pending flags and irq
module input_debouncer #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0]     rise_en,
    input  logic [WIDTH-1:0]     fall_en,
    input  logic [WIDTH-1:0]     clear,
    output logic [WIDTH-1:0]     state,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq
);
    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     s;
    logic [CNT_WIDTH-1:0] cnt [WIDTH];
    logic [CNT_WIDTH-1:0] t_m1;
    assign s    = sync_q[SYNC_STAGES-1];
    assign t_m1 = (threshold == '0) ? '0 : threshold - CNT_WIDTH'(1);
    assign irq  = |pending;
    // synchronizer chain, one bit per channel in each stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
    // stability counters; a channel flips once it has mismatched for T edges in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            state <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= t_m1) begin
                    state[i] <= s[i];
                    cnt[i]   <= '0;
                    rise[i]  <= s[i];
                    fall[i]  <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end
    // sticky pending flags; a new enabled edge wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clear) | (rise & rise_en) | (fall & fall_en);
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: randomized and directed checks of input_debouncer against a run-length reference model
module tb_input_debouncer;
    localparam int W = 4;
    localparam int S = 2;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in = '0;
    logic [C-1:0] threshold = C'(3);
    logic [W-1:0] rise_en = '0;
    logic [W-1:0] fall_en = '0;
    logic [W-1:0] clear = '0;
    logic [W-1:0] state, rise, fall, pending;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hist [S];
    logic [W-1:0] m_state, m_rise, m_fall, m_pend;
    int           run [W];

    input_debouncer #(.WIDTH(W), .SYNC_STAGES(S), .CNT_WIDTH(C)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .threshold(threshold),
        .rise_en(rise_en), .fall_en(fall_en), .clear(clear),
        .state(state), .rise(rise), .fall(fall), .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: s is the raw input delayed S edges; a channel flips after T consecutive mismatching edges
    task model_edge();
        logic [W-1:0] s_now, np;
        int t;
        if (!rst_n) begin
            for (int k = 0; k < S; k++) hist[k] = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
            m_state = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            s_now = hist[S-1];
            for (int k = S-1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in;
            np = (m_pend & ~clear) | (m_rise & rise_en) | (m_fall & fall_en);
            t = (threshold == 0) ? 1 : int'(threshold);
            m_rise = '0; m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (s_now[i] != m_state[i]) begin
                    run[i]++;
                    if (run[i] >= t) begin
                        m_state[i] = s_now[i];
                        if (s_now[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else run[i] = 0;
            end
            m_pend = np;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("irq", 32'(irq), 32'(|m_pend));
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // counts edges until the requested pulse on channel ch; 0 means it never came
    task automatic wait_edge(input int ch, input bit up, input int exp, input string tag);
        int found = 0;
        for (int k = 1; k <= 200 && found == 0; k++) begin
            step();
            if (up ? rise[ch] : fall[ch]) found = k;
        end
        chk(tag, 32'(found), 32'(exp));
    endtask

    initial begin
        int rc;
        // power-on: input held high through reset
        in = 4'b0101;
        settle(3);
        rst_n = 1'b1;
        settle(4);
        chk("por_state_before", 32'(state), 32'h0);
        step();
        chk("por_state", 32'(state), 32'h5);
        chk("por_rise", 32'(rise), 32'h5);
        step();
        chk("por_rise_once", 32'(rise), 32'h0);
        // glitch rejection
        in = '0;
        settle(10);
        threshold = C'(5);
        in[0] = 1'b1;
        settle(4);
        in[0] = 1'b0;
        rc = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            rc += int'(rise[0]);
        end
        chk("glitch_rise", 32'(rc), 32'h0);
        chk("glitch_state", 32'(state[0]), 32'h0);
        in[0] = 1'b1;
        wait_edge(0, 1'b1, 7, "stable_rise_latency");
        // threshold 0 behaves like 1
        threshold = C'(0);
        in[1] = 1'b1;
        wait_edge(1, 1'b1, 3, "thr0_rise");
        in[1] = 1'b0;
        wait_edge(1, 1'b0, 3, "thr0_fall");
        threshold = C'(1);
        in[1] = 1'b1;
        wait_edge(1, 1'b1, 3, "thr1_rise");
        in[1] = 1'b0;
        wait_edge(1, 1'b0, 3, "thr1_fall");
        in[2] = 1'b1;
        step();
        in[2] = 1'b0;
        wait_edge(2, 1'b1, 2, "one_cycle_rise");
        wait_edge(2, 1'b0, 1, "one_cycle_fall");
        // pending and clear
        in = '0;
        threshold = C'(2);
        settle(8);
        rise_en = 4'b0001;
        fall_en = '0;
        clear = '1;
        step();
        clear = '0;
        in[1:0] = 2'b11;
        settle(8);
        in[1:0] = 2'b00;
        settle(8);
        chk("pend_only_ch0", 32'(pending), 32'h1);
        chk("pend_irq", 32'(irq), 32'h1);
        in[0] = 1'b1;
        wait_edge(0, 1'b1, 4, "pend_rise_latency");
        clear = 4'b0001;
        step();
        clear = '0;
        chk("set_beats_clear", 32'(pending[0]), 32'h1);
        clear = 4'b0001;
        step();
        clear = '0;
        chk("clear_alone", 32'(pending), 32'h0);
        chk("irq_low", 32'(irq), 32'h0);
        // lowering threshold mid-count
        threshold = C'(100);
        in[3] = 1'b1;
        settle(52);
        chk("midcount_state", 32'(state[3]), 32'h0);
        threshold = C'(10);
        step();
        chk("midcount_flip", 32'(rise[3]), 32'h1);
        // reset mid-count restarts the full latency
        threshold = C'(20);
        in[2] = 1'b1;
        settle(12);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_edge(2, 1'b1, 22, "reset_restart");
        // all channels at once
        in = '0;
        threshold = C'(2);
        settle(30);
        rise_en = '1;
        clear = '1;
        step();
        clear = '0;
        in = '1;
        wait_edge(0, 1'b1, 4, "multi_latency");
        chk("multi_rise", 32'(rise), 32'hf);
        step();
        chk("multi_pend", 32'(pending), 32'hf);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) threshold = C'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) in[$urandom_range(0, W-1)] ^= 1'b1;
            rise_en = W'($urandom);
            fall_en = W'($urandom);
            clear = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Debounce controller for a bank of asynchronous level inputs such as buttons, switches and external status pins. Each channel passes through its own resettable synchronizer chain and a per-channel stability counter, so the filtered level changes only after the raw input has held a new value for a programmable number of cycles. The block emits one-cycle edge pulses on each filtered transition, keeps sticky pending flags, and drives a single interrupt line toward the CPU's MMIO/interrupt logic.

## Interface
- WIDTH, 4: number of independent input channels.
- SYNC_STAGES, 2: flip-flop stages per channel synchronizer; minimum 2.
- CNT_WIDTH, 16: width of the per-channel stability counter and of `threshold`.

- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  raw asynchronous inputs.
- threshold  input  CNT_WIDTH  stability cycles required before a change is accepted. Quasi-static. Value 0 is treated as 1.
- rise_en  input  WIDTH  per-channel enable for setting pending on a rising edge.
- fall_en  input  WIDTH  per-channel enable for setting pending on a falling edge.
- clear  input  WIDTH  per-channel synchronous clear of pending.
- state  output  WIDTH  debounced level.
- rise  output  WIDTH  one-cycle pulse when `state` goes 0→1.
- fall  output  WIDTH  one-cycle pulse when `state` goes 1→0.
- pending  output  WIDTH  sticky event flags.
- irq  output  1  OR-reduction of `pending`.

## Operation
- Synchronizer: stage0 <= in[i], and stage k <= stage k-1. `s[i]` is the last stage. All stages reset to 0.
- Per channel, on each edge with the effective threshold T = max(threshold, 1):
  - If s == state: cnt <= 0.
  - If s != state and cnt >= T-1: state <= s, cnt <= 0, and the matching rise/fall pulse is asserted for exactly that cycle.
  - Otherwise: cnt <= cnt + 1.
- Glitch rejection: any edge where s == state before the threshold is reached resets cnt. Partial counts are never carried over.
- The `>=` comparison applies at every count, so lowering `threshold` mid-count flips the channel on the next mismatching edge. Raising it extends the wait. cnt never wraps.
- Pending: pending[i] <= (pending[i] & ~clear[i]) | (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]). When set and clear coincide, set wins.
- Edges with a disabled enable still pulse `rise`/`fall` and update `state`, but do not touch `pending`.
- irq = |pending, combinational from registers, with no added latency.
- Channels are fully independent, and simultaneous events on different channels are all captured.

## Timing
- Reset values (rst_n low, asynchronous): all sync stages 0, cnt 0, state 0, rise 0, fall 0, pending 0, irq 0.
- An input held high through reset release produces a normal rise after the full latency. This is intended power-on behaviour.
- Latency: if `in` changes just before edge 1 and stays stable, `s` shows the new value after edge SYNC_STAGES. `state`, `rise` and `fall` update on edge SYNC_STAGES+T.
- Pending is set on the edge after the pulse (edge SYNC_STAGES+T+1), and `irq` asserts in that same cycle.
- rise and fall are never high together on one channel. Each pulse lasts exactly one cycle.
- Reset asserted mid-count discards all progress. The count restarts from 0 after release.
- Minimum reportable pulse width on `in` is T cycles. Shorter pulses produce no event.

## Test plan
- Reset and power-on: hold rst_n=0 with in=4'b0101, then release with threshold=3 and SYNC_STAGES=2. Required: state=0 until edge 5 after release, then state=4'b0101 and rise=4'b0101 for one cycle.
- Glitch rejection: threshold=5, in[0] high for 4 cycles then low. Required: no rise, state[0]=0. Then hold in[0] high for 5 cycles. Required: exactly one rise[0] at edge 2+5 after the change.
- Threshold 0 vs 1: threshold=0 and threshold=1 produce identical timing. A single-cycle stable change is accepted at edge SYNC_STAGES+1.
- Pending and clear: rise_en=4'b0001 and fall_en=0, then toggle in[0] and in[1] high then low. Required: pending=4'b0001 and irq=1 after the rise[0]. No pending from in[1] or from the falls. Assert clear[0] on the same cycle as a new enabled rise[0]. Required: pending[0] remains 1.
- Mid-count changes: threshold=100, count to 50, then change threshold to 10. Required: flip on the next mismatching edge. Separately, assert rst_n low at count 50, then release. Required: the full latency restarts.
- Multi-channel: change all four inputs on the same cycle with rise_en all ones. Required: simultaneous rise=4'b1111 and pending=4'b1111.
